// File: rtl/sha1_ctrl_pkg.sv
// Shared types and constants for the SHA-1 round sequencing controller.
package sha1_ctrl_pkg;

    // Round counter width and round-range constants
    localparam int unsigned CNT_W       = 7;
    localparam int unsigned ROUND_LAST  = 79;
    localparam int unsigned W_LOAD_LAST = 15;

    // Last round index of each 20-round phase
    localparam int unsigned PHASE0_LAST = 19;
    localparam int unsigned PHASE1_LAST = 39;
    localparam int unsigned PHASE2_LAST = 59;

    // Controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_ROUND = 3'd2,
        ST_FINAL = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Round function select encodings; K index uses the same values
    typedef enum logic [1:0] {
        F_CH     = 2'd0,
        F_PAR    = 2'd1,
        F_MAJ    = 2'd2,
        F_PAR_HI = 2'd3
    } f_sel_t;

    // Per-round decode presented to the datapath
    typedef struct packed {
        logic [CNT_W-1:0] idx;
        logic [1:0]       f_sel;
        logic [1:0]       k_sel;
        logic             w_src;
    } round_dec_t;

    // Map a round index onto its 20-round phase
    function automatic logic [1:0] phase_of(input logic [CNT_W-1:0] r);
        logic [1:0] ph;
        if (r <= CNT_W'(PHASE0_LAST)) begin
            ph = F_CH;
        end else if (r <= CNT_W'(PHASE1_LAST)) begin
            ph = F_PAR;
        end else if (r <= CNT_W'(PHASE2_LAST)) begin
            ph = F_MAJ;
        end else begin
            ph = F_PAR_HI;
        end
        return ph;
    endfunction

endpackage

// File: rtl/sha1_round_cnt.sv
// Round counter: 7-bit, enable and synchronous clear, wraps LAST -> 0.
// Exposes the next count so the controller can register its decodes
// in step with the counter.
module sha1_round_cnt
    import sha1_ctrl_pkg::*;
#(
    parameter int unsigned LAST = ROUND_LAST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             last
);

    // Last-round flag from the registered count
    always_comb begin
        last = (count == CNT_W'(LAST));
    end

    // Next count: clear wins, then increment with wrap at LAST
    always_comb begin
        count_next = count;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = last ? '0 : count + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/sha1_round_ctrl.sv
// SHA-1 compression sequencing controller: accepts a block, loads the
// working variables, steps rounds 0..ROUNDS-1 with per-round decodes,
// issues the final hash add and holds done until acknowledged.
// Optional feature: define SHA1_CTRL_STALL_EN to add a ROUND-state stall input.
module sha1_round_ctrl
    import sha1_ctrl_pkg::*;
#(
    parameter int unsigned ROUNDS      = 80,
    parameter int unsigned LOAD_ROUNDS = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SHA1_CTRL_STALL_EN
    input  logic             stall,
`endif
    input  logic             blk_valid,
    input  logic             blk_first,
    output logic             blk_ready,
    output logic             init_ld,
    output logic             iv_sel,
    output logic             round_en,
    output logic [CNT_W-1:0] round_idx,
    output logic [1:0]       f_sel,
    output logic [1:0]       k_sel,
    output logic             w_src,
    output logic             final_add,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             hold;
    logic             cnt_en;
    logic             cnt_clr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             cnt_last;

    // Registered output next-values
    logic             blk_ready_nxt;
    logic             init_ld_nxt;
    logic             iv_sel_nxt;
    logic             round_act_nxt;
    logic             final_add_nxt;
    logic             done_valid_nxt;
    logic             busy_nxt;
    round_dec_t       dec_nxt;

    logic             round_act;
    round_dec_t       dec;

    // Stall only matters in ROUND; absent feature behaves as stall = 0
`ifdef SHA1_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign accept = blk_valid & blk_ready;

    sha1_round_cnt #(
        .LAST (ROUNDS - 1)
    ) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .en         (cnt_en),
        .clr        (cnt_clr),
        .count      (count),
        .count_next (count_next),
        .last       (cnt_last)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and counter control
    always_comb begin
        state_nxt = state;
        cnt_en    = 1'b0;
        cnt_clr   = 1'b1;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_INIT;
                end
            end
            ST_INIT: begin
                state_nxt = ST_ROUND;
            end
            ST_ROUND: begin
                cnt_clr = 1'b0;
                if (!hold) begin
                    cnt_en = 1'b1;
                    if (cnt_last) begin
                        state_nxt = ST_FINAL;
                    end
                end
            end
            ST_FINAL: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state/count, registered below so the
    // outputs are a pure function of the registered state and counter
    always_comb begin
        blk_ready_nxt  = (state_nxt == ST_IDLE);
        init_ld_nxt    = (state_nxt == ST_INIT);
        // INIT is entered only from an accept, so this is the sampled blk_first
        iv_sel_nxt     = accept & blk_first;
        round_act_nxt  = (state_nxt == ST_ROUND);
        final_add_nxt  = (state_nxt == ST_FINAL);
        done_valid_nxt = (state_nxt == ST_DONE);
        busy_nxt       = (state_nxt != ST_IDLE);
        dec_nxt        = '0;
        if (state_nxt == ST_ROUND) begin
            dec_nxt.idx   = count_next;
            dec_nxt.f_sel = phase_of(count_next);
            dec_nxt.k_sel = phase_of(count_next);
            dec_nxt.w_src = (count_next > CNT_W'(LOAD_ROUNDS - 1));
        end
    end

    // Output registers; reset leaves only blk_ready asserted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_ready  <= 1'b1;
            init_ld    <= 1'b0;
            iv_sel     <= 1'b0;
            round_act  <= 1'b0;
            final_add  <= 1'b0;
            done_valid <= 1'b0;
            busy       <= 1'b0;
            dec        <= '0;
        end else begin
            blk_ready  <= blk_ready_nxt;
            init_ld    <= init_ld_nxt;
            iv_sel     <= iv_sel_nxt;
            round_act  <= round_act_nxt;
            final_add  <= final_add_nxt;
            done_valid <= done_valid_nxt;
            busy       <= busy_nxt;
            dec        <= dec_nxt;
        end
    end

    // Round strobe; a stalled ROUND cycle suppresses it
    assign round_en  = round_act & ~hold;
    assign round_idx = dec.idx;
    assign f_sel     = dec.f_sel;
    assign k_sel     = dec.k_sel;
    assign w_src     = dec.w_src;

endmodule

// File: tb/tb_sha1_round_ctrl.sv
// Self-checking bench for sha1_round_ctrl: cycle-level behavioural model,
// directed scenarios with literal expectations, then randomized traffic.
// Define SHA1_CTRL_STALL_EN to exercise the stall build.
module tb_sha1_round_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       blk_valid;
    logic       blk_first;
    logic       blk_ready;
    logic       init_ld;
    logic       iv_sel;
    logic       round_en;
    logic [6:0] round_idx;
    logic [1:0] f_sel;
    logic [1:0] k_sel;
    logic       w_src;
    logic       final_add;
    logic       done_valid;
    logic       done_ready;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int acc_cyc = 0;

    // Model: p = 0 idle, 1 init, 2..81 round p-2, 82 final, 83 done
    int p       = 0;
    bit m_first = 1'b0;

    sha1_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
`ifdef SHA1_CTRL_STALL_EN
        .stall      (stall),
`endif
        .blk_valid  (blk_valid),
        .blk_first  (blk_first),
        .blk_ready  (blk_ready),
        .init_ld    (init_ld),
        .iv_sel     (iv_sel),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .f_sel      (f_sel),
        .k_sel      (k_sel),
        .w_src      (w_src),
        .final_add  (final_add),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural progress model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            p       <= 0;
            m_first <= 1'b0;
        end else if (p == 0) begin
            if (blk_valid) begin
                p       <= 1;
                m_first <= blk_first;
            end
        end else if (p >= 2 && p <= 81 && stall) begin
            p <= p;
        end else if (p >= 83) begin
            if (done_ready) p <= 0;
        end else begin
            p <= p + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, plus per-block round count
    task automatic compare_loop();
        int pulses = 0;
        bit dv_prev = 1'b0;
        bit in_r;
        int idx;
        forever begin
            @(negedge clk);
            in_r = (p >= 2 && p <= 81);
            idx  = in_r ? p - 2 : 0;
            chk("blk_ready",  int'(blk_ready),  int'(p == 0));
            chk("init_ld",    int'(init_ld),    int'(p == 1));
            chk("iv_sel",     int'(iv_sel),     int'(p == 1 && m_first));
            chk("round_en",   int'(round_en),   int'(in_r && !stall));
            chk("round_idx",  int'(round_idx),  idx);
            chk("f_sel",      int'(f_sel),      in_r ? idx / 20 : 0);
            chk("k_sel",      int'(k_sel),      in_r ? idx / 20 : 0);
            chk("w_src",      int'(w_src),      int'(in_r && idx >= 16));
            chk("final_add",  int'(final_add),  int'(p == 82));
            chk("done_valid", int'(done_valid), int'(p >= 83));
            chk("busy",       int'(busy),       int'(p != 0));
            if (rst || init_ld) pulses = 0;
            if (round_en) pulses++;
            if (done_valid && !dv_prev) chk("round_pulses", pulses, 80);
            dv_prev = done_valid;
        end
    endtask

    task automatic accept_block(input bit first);
        int n = 0;
        while (!blk_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("accept_ready_timeout", int'(blk_ready), 1);
        blk_valid = 1'b1;
        blk_first = first;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        blk_first = 1'b0;
        acc_cyc   = cyc;
    endtask

    task automatic wait_idx(input int target);
        int n = 0;
        while (!(busy && int'(round_idx) == target) && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_idx_timeout", int'(round_idx), target);
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (!done_valid && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", int'(done_valid), 1);
        lat = cyc - acc_cyc + 1;
    endtask

    task automatic ack_done();
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int nacc;
        int accs [3];
        rst        = 1'b1;
        stall      = 1'b0;
        blk_valid  = 1'b0;
        blk_first  = 1'b0;
        done_ready = 1'b0;
        fork
            compare_loop();
        join_none
        repeat (3) @(posedge clk);
        #1;
        chk("rst_blk_ready", int'(blk_ready), 1);
        chk("rst_busy",      int'(busy),      0);
        rst = 1'b0;

        // First block from the IV: literal pins on timing and decodes
        accept_block(1'b1);
        chk("t1_init_ld", int'(init_ld), 1);
        chk("t1_iv_sel",  int'(iv_sel),  1);
        chk("t1_ready",   int'(blk_ready), 0);
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            chk("t1_idx", int'(round_idx), i);
            chk("t1_en",  int'(round_en), 1);
            case (i)
                0:  begin chk("r0_f", int'(f_sel), 0); chk("r0_w", int'(w_src), 0); end
                15: chk("r15_w", int'(w_src), 0);
                16: chk("r16_w", int'(w_src), 1);
                19: chk("r19_f", int'(f_sel), 0);
                20: begin chk("r20_f", int'(f_sel), 1); chk("r20_k", int'(k_sel), 1); end
                39: chk("r39_k", int'(k_sel), 1);
                40: begin chk("r40_f", int'(f_sel), 2); chk("r40_k", int'(k_sel), 2); end
                60: begin chk("r60_f", int'(f_sel), 3); chk("r60_k", int'(k_sel), 3); end
                79: chk("r79_f", int'(f_sel), 3);
                default: ;
            endcase
        end
        @(posedge clk); #1;
        chk("t1_final_add", int'(final_add), 1);
        chk("t1_final_idx", int'(round_idx), 0);
        @(posedge clk); #1;
        chk("t1_done", int'(done_valid), 1);
        chk("t1_latency", cyc - acc_cyc + 1, 83);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_done_valid", int'(done_valid), 1);
            chk("hold_blk_ready",  int'(blk_ready),  0);
        end
        ack_done();
        chk("ack_blk_ready", int'(blk_ready), 1);
        chk("ack_done_low",  int'(done_valid), 0);

        // Continuation block uses the current hash state
        accept_block(1'b0);
        chk("t2_init_ld", int'(init_ld), 1);
        chk("t2_iv_sel",  int'(iv_sel),  0);
        wait_done(lat);
        chk("t2_latency", lat, 83);
        ack_done();

        // Asynchronous reset in the middle of round 37
        accept_block(1'b1);
        wait_idx(37);
        #2 rst = 1'b1;
        #1;
        chk("arst_blk_ready", int'(blk_ready), 1);
        chk("arst_round_en",  int'(round_en),  0);
        chk("arst_round_idx", int'(round_idx), 0);
        chk("arst_busy",      int'(busy),      0);
        @(posedge clk); #1;
        rst = 1'b0;
        accept_block(1'b0);
        wait_done(lat);
        chk("post_rst_latency", lat, 83);
        ack_done();

`ifdef SHA1_CTRL_STALL_EN
        // Five stalled cycles at round 50
        accept_block(1'b1);
        wait_idx(50);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_idx", int'(round_idx), 50);
            chk("stall_en",  int'(round_en),  0);
            @(posedge clk); #1;
        end
        stall = 1'b0;
        #1;
        chk("unstall_idx", int'(round_idx), 50);
        chk("unstall_en",  int'(round_en),  1);
        wait_done(lat);
        chk("stall_latency", lat, 88);
        ack_done();
`endif

        // Back-to-back blocks with done_ready tied high
        done_ready = 1'b1;
        blk_valid  = 1'b1;
        blk_first  = 1'b0;
        nacc = 0;
        accs = '{0, 0, 0};
        for (int n = 0; n < 400 && nacc < 3; n++) begin
            @(posedge clk); #1;
            if (init_ld) begin
                accs[nacc] = cyc;
                nacc++;
            end
        end
        blk_valid = 1'b0;
        chk("b2b_accepts", nacc, 3);
        chk("b2b_gap1", accs[1] - accs[0], 84);
        chk("b2b_gap2", accs[2] - accs[1], 84);
        repeat (100) @(posedge clk);
        #1;
        done_ready = 1'b0;
        chk("b2b_idle", int'(blk_ready), 1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            blk_valid  = ($urandom_range(0, 3) == 0);
            blk_first  = 1'($urandom_range(0, 1));
            done_ready = ($urandom_range(0, 2) == 0);
`ifdef SHA1_CTRL_STALL_EN
            stall      = ($urandom_range(0, 5) == 0);
`endif
        end
        blk_valid  = 1'b0;
        stall      = 1'b0;
        done_ready = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        chk("drain_idle", int'(blk_ready), 1);
        done_ready = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha1_round_ctrl.md
# sha1_round_ctrl

Sequencing controller for the SHA-1 compression datapath. It accepts one 512-bit message block per handshake, initialises the working variables, and steps the round datapath through rounds 0–79. Its per-round decodes select the round function, the K constant and the W source. It then issues the final hash-state add and holds a done handshake until the consumer acknowledges it. It sits between the block-input FIFO and the round/message-schedule datapath.

## Interface
Parameters:
- ROUNDS, 80, number of compression rounds; the last index is ROUNDS-1.
- LOAD_ROUNDS, 16, number of rounds that take W directly from the message block.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- blk_valid  in  1  a message block is presented.
- blk_first  in  1  the block is the first of a message; sampled on accept.
- blk_ready  out  1  controller can accept a block.
- init_ld  out  1  load A–E from the hash state (or from the IV).
- iv_sel  out  1  1 = init_ld sources the IV; 0 = sources the current hash state.
- round_en  out  1  datapath performs one round this cycle.
- round_idx  out  7  current round, 0..79.
- f_sel  out  2  0 = Ch (rounds 0–19), 1 = Parity (20–39), 2 = Maj (40–59), 3 = Parity (60–79).
- k_sel  out  2  K constant index; same ranges as f_sel.
- w_src  out  1  0 = message word (round < 16), 1 = expanded schedule word.
- final_add  out  1  add A–E into the hash state.
- done_valid  out  1  hash state updated for this block.
- done_ready  in  1  consumer acknowledges done.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, INIT, ROUND, FINAL, DONE.
- IDLE: blk_ready = 1. Accept = blk_valid & blk_ready.
  - On accept: register blk_first, go to INIT.
- INIT: one cycle. init_ld = 1, iv_sel = registered blk_first. Go to ROUND with counter = 0.
- ROUND:
  - round_en = 1 and round_idx = counter.
  - Counter increments each cycle.
  - At counter 79, wrap to 0 and go to FINAL.
- FINAL: one cycle. final_add = 1. Go to DONE.
- DONE:
  - done_valid = 1 until done_ready is sampled high, then go to IDLE.
  - done_valid & done_ready in the same cycle counts as an immediate acknowledge.
  - blk_ready = 0 in DONE, so a new block cannot be accepted in the acknowledge cycle.
- Decode outputs (f_sel, k_sel, w_src, round_idx) are driven only in ROUND and are 0 elsewhere.
- All outputs are Moore decodes of the registered state and counter. No input-to-output combinational path exists.
- Counter arithmetic is 7-bit unsigned. The counter never exceeds 79. The counter is held at 0 outside ROUND.
- Reset, including mid-operation:
  - State goes to IDLE and the counter to 0.
  - Every output is 0 except blk_ready = 1.
  - The block in progress is dropped and no done is issued.

## Timing
- Accept on edge T. Then:
  - INIT occupies cycle T+1.
  - ROUND occupies cycles T+2..T+81 (round_idx 0..79).
  - FINAL occupies cycle T+82.
  - done_valid rises at T+83.
- Minimum block period is 84 cycles (done acknowledged in its first cycle, re-accept one cycle later).
- blk_ready falls on the edge following accept.
- f_sel and k_sel boundaries change on the edges entering rounds 20, 40 and 60. w_src rises entering round 16.

## Configuration
- SHA1_CTRL_STALL_EN defined:
  - Adds input port stall (1 bit).
  - In ROUND with stall = 1: round_en = 0; the counter, state and decode outputs hold.
  - stall is ignored in all other states.
  - Latency grows by one cycle per stalled ROUND cycle.
- SHA1_CTRL_STALL_EN undefined: the port is absent and behaviour is exactly as if stall = 0.

## Structure
- Package sha1_ctrl_pkg holds:
  - the FSM state enum;
  - ROUND_LAST = 79 and W_LOAD_LAST = 15;
  - phase boundaries 19, 39 and 59;
  - f_sel encodings (F_CH, F_PAR, F_MAJ).
- Sub-module sha1_round_cnt: a 7-bit counter with enable and clear, wrapping 79→0, with a last-round flag output. The FSM and decode logic stay in sha1_round_ctrl.

## Test plan
- Reset, then blk_valid = 1, blk_first = 1 → init_ld = iv_sel = 1 one cycle later; round_idx runs 0..79; final_add one cycle; done_valid at T+83.
- Check decodes across all rounds → f_sel = 0/1/2/3 and k_sel likewise at rounds 0/20/40/60; w_src = 0 for rounds 0–15 and 1 for rounds 16–79.
- Hold done_ready = 0 for 10 cycles → done_valid stays 1 and blk_ready stays 0. Then raise done_ready → IDLE next cycle; a second block with blk_first = 0 gives iv_sel = 0.
- Assert rst asynchronously at round 37 → outputs clear immediately and blk_ready = 1; after release, a new block runs all 80 rounds normally.
- With SHA1_CTRL_STALL_EN defined, stall 5 cycles at round 50 → round_idx holds at 50 with round_en = 0, and done_valid arrives at T+88.
- Back-to-back blocks with done_ready tied to 1 → accept edges are 84 cycles apart and exactly 80 round_en pulses occur per block.
